// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding into the ALU operands.
// Optional FORWARD_EN: forwarding muxes; otherwise load_use flags any RAW hazard.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dest,
    input  logic [3:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_shift,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_result,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] ex_store_data,
    output logic        ex_valid,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        load_use
);

    localparam logic [3:0] OP_NOP = 4'b1000;

    logic        r_valid;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic [4:0]  r_shamt;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_dest;
    logic [3:0]  r_alu_op;
    logic        r_alu_src;
    logic        r_shift;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_mem_to_reg;

    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;

`ifdef FORWARD_EN
    logic w_mem_rs;
    logic w_mem_rt;
    logic w_wb_rs;
    logic w_wb_rt;

    assign w_mem_rs = mem_reg_write && (mem_dest != 5'd0)
                      && (mem_dest == r_rs);
    assign w_mem_rt = mem_reg_write && (mem_dest != 5'd0)
                      && (mem_dest == r_rt);
    assign w_wb_rs  = wb_reg_write && (wb_dest != 5'd0)
                      && (wb_dest == r_rs);
    assign w_wb_rt  = wb_reg_write && (wb_dest != 5'd0)
                      && (wb_dest == r_rt);

    // MEM is the younger producer, so it wins over WB
    always_comb begin
        w_fwd_rs = r_rs_data;
        priority case (1'b1)
            w_mem_rs: w_fwd_rs = mem_result;
            w_wb_rs:  w_fwd_rs = wb_result;
            default:  w_fwd_rs = r_rs_data;
        endcase
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        priority case (1'b1)
            w_mem_rt: w_fwd_rt = mem_result;
            w_wb_rt:  w_fwd_rt = wb_result;
            default:  w_fwd_rt = r_rt_data;
        endcase
    end

    assign load_use = r_valid && r_mem_read && (r_dest != 5'd0)
                      && ((r_dest == id_rs) || (r_dest == id_rt))
                      && id_valid;
`else
    logic w_raw_rs;
    logic w_raw_rt;
    logic w_unused;

    assign w_fwd_rs = r_rs_data;
    assign w_fwd_rt = r_rt_data;

    assign w_raw_rs = (id_rs != 5'd0) && (
                      (r_valid && r_reg_write && (r_dest == id_rs))
                      || (mem_reg_write && (mem_dest == id_rs)));
    assign w_raw_rt = (id_rt != 5'd0) && (
                      (r_valid && r_reg_write && (r_dest == id_rt))
                      || (mem_reg_write && (mem_dest == id_rt)));

    assign load_use = id_valid && (w_raw_rs || w_raw_rt);

    assign w_unused = &{1'b0, mem_result, wb_reg_write, wb_dest,
                        wb_result, r_rs, r_rt};
`endif

    // a stall rewrites the operands so a retiring WB value is kept
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid      <= 1'b0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_shamt      <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_dest       <= '0;
            r_alu_op     <= OP_NOP;
            r_alu_src    <= 1'b0;
            r_shift      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (stall) begin
            r_rs_data <= w_fwd_rs;
            r_rt_data <= w_fwd_rt;
        end else begin
            r_valid      <= id_valid;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
            r_shamt      <= id_shamt;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_dest       <= id_dest;
            r_alu_op     <= id_alu_op;
            r_alu_src    <= id_alu_src;
            r_shift      <= id_shift;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
        end
    end

    assign alu_op        = r_alu_op;
    assign alu_a         = r_shift ? {27'b0, r_shamt} : w_fwd_rs;
    assign alu_b         = r_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_valid      = r_valid;
    assign ex_dest       = r_dest;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed cases then random traffic,
// checked against an instruction-level model of the EX slot.
module tb_id_ex_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_dest;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_shift;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_dest, wb_dest;
    logic [31:0] mem_result, wb_result;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic        ex_valid;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_shift(id_shift), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
        .wb_result(wb_result),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .load_use(load_use)
    );

    typedef struct {
        logic        rst, flush, stall, valid;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  shamt, rs, rt, dest;
        logic [3:0]  op;
        logic        src, sh, rw, mr, mw, m2r;
        logic        mrw;
        logic [4:0]  md;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wd;
        logic [31:0] wres;
    } stim_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, sd;
        logic        v;
        logic [4:0]  dest;
        logic        rw, mr, mw, m2r, lu;
    } exp_t;

    exp_t  q[$];
    stim_t cur;
    stim_t m;
    int    n_pass = 0;
    int    n_total = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     n, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t bubble();
        stim_t s;
        s = '{default: '0};
        s.op = 4'b1000;
        return s;
    endfunction

    // value the EX slot sees for register idx, given the producers in s
    function automatic logic [31:0] fwd(input logic [4:0] idx,
                                        input logic [31:0] d,
                                        input stim_t s);
`ifdef FORWARD_EN
        if (s.mrw && s.md != 0 && s.md == idx) return s.mres;
        if (s.wrw && s.wd != 0 && s.wd == idx) return s.wres;
`endif
        return d;
    endfunction

    function automatic logic raw(input logic [4:0] idx, input stim_t ex,
                                 input stim_t s);
        if (idx == 0) return 1'b0;
        return (ex.valid && ex.rw && ex.dest == idx)
               || (s.mrw && s.md == idx);
    endfunction

    function automatic exp_t predict(input stim_t ex, input stim_t s);
        exp_t e;
        logic [31:0] frs, frt;
        frs   = fwd(ex.rs, ex.rs_d, s);
        frt   = fwd(ex.rt, ex.rt_d, s);
        e.op  = ex.op;
        e.a   = ex.sh ? {27'b0, ex.shamt} : frs;
        e.b   = ex.src ? ex.imm : frt;
        e.sd  = frt;
        e.v   = ex.valid;
        e.dest = ex.dest;
        e.rw  = ex.rw;
        e.mr  = ex.mr;
        e.mw  = ex.mw;
        e.m2r = ex.m2r;
`ifdef FORWARD_EN
        e.lu = s.valid && ex.valid && ex.mr && ex.dest != 0
               && (ex.dest == s.rs || ex.dest == s.rt);
`else
        e.lu = s.valid && (raw(s.rs, ex, s) || raw(s.rt, ex, s));
`endif
        return e;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst; flush = s.flush; stall = s.stall;
        id_valid = s.valid;
        id_rs_data = s.rs_d; id_rt_data = s.rt_d; id_imm = s.imm;
        id_shamt = s.shamt; id_rs = s.rs; id_rt = s.rt;
        id_dest = s.dest; id_alu_op = s.op;
        id_alu_src = s.src; id_shift = s.sh;
        id_reg_write = s.rw; id_mem_read = s.mr;
        id_mem_write = s.mw; id_mem_to_reg = s.m2r;
        mem_reg_write = s.mrw; mem_dest = s.md; mem_result = s.mres;
        wb_reg_write = s.wrw; wb_dest = s.wd; wb_result = s.wres;
    endtask

    // one cycle: retire the edge into the model, then present s
    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        if (cur.rst || cur.flush) begin
            m = bubble();
        end else if (cur.stall) begin
            m.rs_d = fwd(m.rs, m.rs_d, cur);
            m.rt_d = fwd(m.rt, m.rt_d, cur);
        end else begin
            m = cur;
        end
        cur = s;
        drive(s);
        q.push_back(predict(m, s));
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.rst   = ($urandom_range(0, 49) == 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.stall = ($urandom_range(0, 4) == 0);
        s.valid = $urandom_range(0, 1);
        s.rs_d  = $urandom;
        s.rt_d  = $urandom;
        s.imm   = $urandom;
        s.shamt = 5'($urandom_range(0, 31));
        s.rs    = 5'($urandom_range(0, 4));
        s.rt    = 5'($urandom_range(0, 4));
        s.dest  = 5'($urandom_range(0, 4));
        s.op    = 4'($urandom_range(0, 15));
        s.src   = $urandom_range(0, 1);
        s.sh    = ($urandom_range(0, 3) == 0);
        s.rw    = $urandom_range(0, 1);
        s.mr    = $urandom_range(0, 1);
        s.mw    = $urandom_range(0, 1);
        s.m2r   = $urandom_range(0, 1);
        s.mrw   = $urandom_range(0, 1);
        s.md    = 5'($urandom_range(0, 4));
        s.mres  = $urandom;
        s.wrw   = $urandom_range(0, 1);
        s.wd    = 5'($urandom_range(0, 4));
        s.wres  = $urandom;
        return s;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("alu_op", 32'(alu_op), 32'(e.op));
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                chk("store_data", ex_store_data, e.sd);
                chk("ex_valid", 32'(ex_valid), 32'(e.v));
                chk("ex_dest", 32'(ex_dest), 32'(e.dest));
                chk("ex_ctrl",
                    32'({ex_reg_write, ex_mem_read,
                         ex_mem_write, ex_mem_to_reg}),
                    32'({e.rw, e.mr, e.mw, e.m2r}));
                chk("load_use", 32'(load_use), 32'(e.lu));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        cur = idle();
        cur.rst = 1'b1;
        m = bubble();
        drive(cur);
        s = idle(); s.rst = 1'b1;
        step(s);
        step(s);
        // register path
        s = idle(); s.valid = 1; s.rs_d = 5; s.imm = 7;
        s.src = 1; s.op = 4'b0010;
        step(s);
        // forward priority, rs = 3
        s = idle(); s.valid = 1; s.rs = 3; s.rs_d = 1;
        step(s);
        s = idle(); s.stall = 1;
        s.mrw = 1; s.md = 3; s.mres = 32'hAA;
        s.wrw = 1; s.wd = 3; s.wres = 32'hBB;
        step(s);
        s.mrw = 0;
        step(s);
        s = idle(); s.valid = 1; s.rs = 0; s.rs_d = 9;
        step(s);
        s = idle(); s.stall = 1; s.wrw = 1; s.wd = 0; s.wres = 32'hCC;
        step(s);
        // stall refresh
        s = idle(); s.valid = 1; s.rs = 6; s.rs_d = 1; s.op = 4'b0001;
        s.dest = 2; s.rw = 1;
        step(s);
        s = idle(); s.stall = 1; s.wrw = 1; s.wd = 6; s.wres = 32'h55;
        step(s);
        s = idle(); s.stall = 1;
        step(s);
        step(s);
        // load-use then flush with stall
        s = idle(); s.valid = 1; s.mr = 1; s.rw = 1; s.m2r = 1; s.dest = 4;
        step(s);
        s = idle(); s.valid = 1; s.rs = 4;
        step(s);
        s.stall = 1; s.flush = 1;
        step(s);
        // shift
        s = idle(); s.valid = 1; s.sh = 1; s.shamt = 3; s.rt_d = 1;
        s.op = 4'b0011;
        step(s);
        // RAW against a MEM destination only
        s = idle(); s.valid = 1; s.rs = 5; s.mrw = 1; s.md = 5;
        s.mres = 32'h77;
        step(s);
        // reset while stalled
        s = idle(); s.stall = 1; s.rst = 1;
        step(s);
        step(idle());
        for (int i = 0; i < 500; i++) step(rnd());
        step(idle());
        step(idle());
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        n_total++;
        if (q.size() != 0)
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand front end for the pipelined MIPS core. Captures decoded operands and control from ID, applies stall/flush, resolves RAW hazards by forwarding from MEM and WB, and drives the ALU's `op`, `a` and `b` inputs directly. Also flags load-use hazards back to the hazard unit so ID/IF can be stalled.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register index, 4-bit ALU op.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` input 1: clock.
  - `rst` input 1: active-high synchronous reset.
- ID-side inputs:
  - `stall` input 1: hold the EX contents.
  - `flush` input 1: load a bubble.
  - `id_valid` input 1: the ID slot holds a real instruction.
  - `id_rs_data`, `id_rt_data` input 32: register file read data.
  - `id_imm` input 32: extended immediate.
  - `id_shamt` input 5: shift amount.
  - `id_rs`, `id_rt`, `id_dest` input 5: source and destination register indices.
  - `id_alu_op` input 4: ALU function code.
  - `id_alu_src` input 1: 1 selects the immediate as b.
  - `id_shift` input 1: 1 selects the zero-extended shamt as a.
  - `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` input 1 each: control bits.
- Forwarding sources:
  - `mem_reg_write` input 1, `mem_dest` input 5, `mem_result` input 32: MEM-stage producer.
  - `wb_reg_write` input 1, `wb_dest` input 5, `wb_result` input 32: WB-stage producer.
- Outputs to the ALU and EX/MEM:
  - `alu_op` output 4: ALU function code.
  - `alu_a`, `alu_b` output 32: ALU operands.
  - `ex_store_data` output 32: forwarded rt value, used by stores.
  - `ex_valid` output 1: the EX slot holds a real instruction.
  - `ex_dest` output 5: EX destination register.
  - `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` output 1 each: registered control bits.
- Hazard output:
  - `load_use` output 1: load-use hazard request to the hazard unit.

## Operation
- **Register update** (rising `clk`), in priority order: `rst` > `flush` > `stall` > load.
  - `rst` and `flush`: load a bubble. All data and index fields become 0, all control bits become 0, `ex_valid`=0, and the stored ALU op becomes 4'b1000 (ALU outputs 0).
  - `stall`: every field holds, except the stored rs/rt data. These are rewritten with their current forwarded values, so a producer that retires from WB during the stall is not lost.
  - Load: every field is captured from the `id_*` inputs.
- **Forwarding** (combinational, applied to stored rs data and rt data independently):
  - MEM match: `mem_reg_write` && `mem_dest`!=0 && `mem_dest`==index → use `mem_result`.
  - Otherwise WB match (same condition on `wb_*`) → use `wb_result`.
  - Otherwise use the stored data.
  - MEM has priority over WB. Register 0 is never forwarded.
- **Operand select:**
  - `alu_a` = `id_shift` ? {27'b0, shamt} : fwd_rs. The ALU computes shifts as b << a.
  - `alu_b` = `id_alu_src` ? imm : fwd_rt.
  - `ex_store_data` = fwd_rt, always.
- **Load-use detection:** `load_use` = `ex_valid` && `ex_mem_read` && `ex_dest`!=0 && (`ex_dest`==`id_rs` || `ex_dest`==`id_rt`) && `id_valid`. The hazard unit converts this into `stall` upstream and `flush` into this block.

## Timing
- Latency: ID inputs appear on the registered outputs 1 cycle after the capturing edge.
- `alu_op`, `alu_a`, `alu_b`, `ex_store_data` and `load_use` are combinational from the registers and the forwarding inputs within the EX cycle. There is no added cycle.
- Reset values:
  - `alu_op`=4'b1000.
  - `alu_a`=`alu_b`=`ex_store_data`=0, provided no forwarding source is active; stored indices are 0, so nothing matches.
  - All other outputs 0.
- Boundary cases:
  - `flush` and `stall` in the same cycle → bubble.
  - `rst` mid-stall → bubble on that edge.
  - MEM and WB both targeting the same register → MEM value wins.
  - Destination index 0 is never forwarded, even if its write-enable is set.

## Configuration
- `FORWARD_EN` defined:
  - Forwarding as described above.
  - `load_use` flags load-use only.
- `FORWARD_EN` undefined:
  - Forwarding muxes are removed; operands come only from the stored data, and the stall refresh holds the data unchanged.
  - `load_use` asserts for any RAW hazard, i.e. the ID rs/rt index (nonzero) matches a valid EX destination with `ex_reg_write`, or a MEM destination with `mem_reg_write`.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `alu_op`=4'b1000, `alu_a`=`alu_b`=0, `ex_valid`=0, all control bits 0.
- **Register path:** load `id_rs_data`=5, `id_imm`=7, `id_alu_src`=1, `id_alu_op`=4'b0010 → next cycle `alu_a`=5, `alu_b`=7, `alu_op`=4'b0010.
- **Forward priority:** EX rs=3; `mem_dest`=3 with `mem_result`=0xAA; `wb_dest`=3 with `wb_result`=0xBB → `alu_a`=0xAA. Deassert `mem_reg_write` → `alu_a`=0xBB. Set `wb_dest`=0 with index 0 → no forward.
- **Stall refresh:** `stall`=1 while WB forwards 0x55 to rs; the next cycle WB is idle → `alu_a` stays 0x55, and all other fields are unchanged.
- **Load-use and flush:** EX holds lw with dest 4; ID presents rs=4 → `load_use`=1. `flush`=1 together with `stall`=1 → next cycle `ex_valid`=0, `alu_op`=4'b1000.
- **Shift:** `id_shift`=1, `id_shamt`=3, `id_rt_data`=1, `id_alu_op`=4'b0011 → `alu_a`=3, `alu_b`=1. Without `FORWARD_EN`, a RAW hazard against the MEM destination asserts `load_use`.
